// File: rtl/mem_trace_monitor_if.sv
// Trace read port of mem_trace_monitor: first-word-fall-through head entry plus pop strobe.
// The monitor drives the head (master); the host or bench consumes it (slave).
interface mem_trace_monitor_if #(
   parameter int unsigned PC_W   = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 16
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic              tr_rd_en;
   logic              tr_valid;
   logic [PC_W-1:0]   tr_pc;
   logic [ADDR_W-1:0] tr_addr;
   logic [DATA_W-1:0] tr_data;
   logic [CNT_W-1:0]  tr_count;

   modport master (
      input  tr_rd_en,
      output tr_valid, tr_pc, tr_addr, tr_data, tr_count
   );

   modport slave (
      output tr_rd_en,
      input  tr_valid, tr_pc, tr_addr, tr_data, tr_count
   );
endinterface

// File: rtl/mem_trace_monitor.sv
// Run monitor for the 16-bit CPU: traces data-memory writes into a FIFO, detects the halt
// instruction at writeback, drains for DRAIN_CYCLES, then freezes with done raised.
module mem_trace_monitor #(
   parameter int unsigned         DATA_W       = 16,
   parameter int unsigned         ADDR_W       = 16,
   parameter int unsigned         PC_W         = 16,
   parameter int unsigned         INSTR_W      = 16,
   parameter int unsigned         DEPTH        = 16,
   parameter logic [INSTR_W-1:0]  HALT_INSTR   = 'hF000,
   parameter int unsigned         DRAIN_CYCLES = 1,
   parameter int unsigned         CAPTURE_RMW  = 0,
   parameter int unsigned         CYC_W        = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wb_valid,
   input  logic [INSTR_W-1:0]     wb_instr,
   input  logic [PC_W-1:0]        id_pc,
   input  logic                   dm_we,
   input  logic                   dm_re,
   input  logic [ADDR_W-1:0]      dm_addr,
   input  logic [DATA_W-1:0]      dm_out,
   mem_trace_monitor_if.master    trace,
   output logic                   overflow,
   output logic [15:0]            drop_cnt,
   output logic                   halt_seen,
   output logic                   done,
   output logic [CYC_W-1:0]       cyc_cnt
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned DRN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam int unsigned ENT_W = PC_W + ADDR_W + DATA_W;

   typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

   state_e             state_q, state_d;
   logic [DRN_W-1:0]   drain_q, drain_d;
   logic               halt_seen_q, halt_seen_d;
   logic [CYC_W-1:0]   cyc_q;

   logic [ENT_W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               overflow_q;
   logic [15:0]        drop_q;

   logic halt_det, running, cap, empty, full, push, pop, drop;
   logic [ENT_W-1:0] head;

   assign halt_det = wb_valid && (wb_instr == HALT_INSTR);
   assign running  = (state_q != StDone);

   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      halt_seen_d = 1'b0;
      unique case (state_q)
         StRun: begin
            if (halt_det) begin
               halt_seen_d = 1'b1;
               drain_d     = DRN_W'(DRAIN_CYCLES);
               state_d     = (DRAIN_CYCLES == 0) ? StDone : StDrain;
            end
         end
         StDrain: begin
            if (drain_q <= DRN_W'(1)) state_d = StDone;
            else                      drain_d = drain_q - DRN_W'(1);
         end
         StDone:  state_d = StDone;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         drain_q     <= '0;
         halt_seen_q <= 1'b0;
         cyc_q       <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         halt_seen_q <= halt_seen_d;
         if (running && (cyc_q != '1)) cyc_q <= cyc_q + CYC_W'(1);
      end
   end

   // A pop at full frees the slot the simultaneous push needs, so nothing is dropped.
   assign cap   = dm_we && (!dm_re || (CAPTURE_RMW != 0)) && running;
   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign pop   = trace.tr_rd_en && !empty;
   assign push  = cap && (!full || pop);
   assign drop  = cap && full && !pop;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {id_pc, dm_addr, dm_out};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         end
      end
   end

   assign head           = empty ? '0 : mem_q[rd_ptr_q];
   assign trace.tr_valid = !empty;
   assign trace.tr_pc    = head[ENT_W-1 -: PC_W];
   assign trace.tr_addr  = head[DATA_W +: ADDR_W];
   assign trace.tr_data  = head[DATA_W-1:0];
   assign trace.tr_count = count_q;

   assign overflow  = overflow_q;
   assign drop_cnt  = drop_q;
   assign halt_seen = halt_seen_q;
   assign done      = (state_q == StDone);
   assign cyc_cnt   = cyc_q;
endmodule
